// File: rtl/md5_guess_generator_pkg.sv
// Shared definitions for the MD5 guess generator and its controller:
// FSM state encodings, default character range, guess width and small helpers.
package md5_guess_generator_pkg;

    localparam int         GUESS_W     = 128;
    localparam logic [7:0] CHAR_LO_DEF = 8'h61;
    localparam logic [7:0] CHAR_HI_DEF = 8'h7A;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PRESENT = 2'd1;
    localparam logic [1:0] ST_ADVANCE = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    // A zero step would never advance the odometer, so it behaves as one.
    function automatic logic [2:0] eff_step(input logic [2:0] inc);
        return (inc == 3'd0) ? 3'd1 : inc;
    endfunction

    // The first character falls back to the bottom of the range when out of range.
    function automatic logic [7:0] first_char(input logic [7:0] pos,
                                              input logic [7:0] lo,
                                              input logic [7:0] hi);
        return (pos >= lo && pos <= hi) ? pos : lo;
    endfunction

endpackage

// File: rtl/md5_char_step.sv
// One odometer digit: add step plus carry-in, wrap once past CHAR_HI and
// raise carry-out for the digit to the left.
module md5_char_step
    import md5_guess_generator_pkg::*;
#(
    parameter logic [7:0] CHAR_LO = CHAR_LO_DEF,
    parameter logic [7:0] CHAR_HI = CHAR_HI_DEF
) (
    input  logic [7:0] digit_i,
    input  logic [2:0] step_i,
    input  logic       carry_i,
    output logic [7:0] digit_o,
    output logic       carry_o
);

    localparam logic [8:0] RANGE = {1'b0, CHAR_HI} - {1'b0, CHAR_LO} + 9'd1;

    logic [8:0] sum;
    logic [8:0] wrapped;

    assign sum     = {1'b0, digit_i} + {6'b0, step_i} + {8'b0, carry_i};
    assign wrapped = sum - RANGE;
    assign carry_o = (sum > {1'b0, CHAR_HI});
    assign digit_o = carry_o ? wrapped[7:0] : sum[7:0];

endmodule

// File: rtl/md5_guess_generator.sv
// Brute-force plaintext candidate generator: an odometer over
// [CHAR_LO,CHAR_HI] growing from length 1 to MAX_LEN, handed out on valid/ready.
module md5_guess_generator
    import md5_guess_generator_pkg::*;
#(
    parameter int         MAX_LEN = 5,
    parameter logic [7:0] CHAR_LO = CHAR_LO_DEF,
    parameter logic [7:0] CHAR_HI = CHAR_HI_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [2:0]         increment,
    input  logic [7:0]         starting_position,
    input  logic               stop,
    input  logic               guess_ready,
    output logic               guess_valid,
    output logic [GUESS_W-1:0] guess,
    output logic [4:0]         guess_len,
    output logic               busy,
    output logic               exhausted,
    output logic [31:0]        count
);

    localparam logic [4:0] MAX_LEN_W = 5'(MAX_LEN);

    logic [1:0]               state_q, state_d;
    logic [MAX_LEN-1:0][7:0]  chars_q, chars_d;
    logic [4:0]               len_q, len_d;
    logic [31:0]              count_q, count_d;

    logic [MAX_LEN-1:0][7:0]  nxt;
    logic                     carry_top;

    // Ripple chain: the step enters at the last live character, carries move left.
    for (genvar i = 0; i < MAX_LEN; i++) begin : g_dig
        logic [2:0] stp;
        logic       cin;
        logic       co;
        assign stp = (5'(i) == len_q - 5'd1) ? eff_step(increment) : 3'd0;
        if (i == MAX_LEN - 1) begin : g_last
            assign cin = 1'b0;
        end else begin : g_mid
            assign cin = (5'(i + 1) < len_q) ? g_dig[i+1].co : 1'b0;
        end
        md5_char_step #(.CHAR_LO(CHAR_LO), .CHAR_HI(CHAR_HI)) u_step (
            .digit_i (chars_q[i]),
            .step_i  (stp),
            .carry_i (cin),
            .digit_o (nxt[i]),
            .carry_o (co)
        );
    end

    assign carry_top = g_dig[0].co;

    // Next-state: FSM transitions, guess load/advance, saturating accept count.
    always_comb begin
        state_d = state_q;
        chars_d = chars_q;
        len_d   = len_q;
        count_d = count_q;
        if ((state_q == ST_IDLE || (state_q == ST_DONE && !stop)) && start) begin
            state_d = ST_PRESENT;
            len_d   = 5'd1;
            count_d = '0;
            chars_d = '0;
            chars_d[0] = first_char(starting_position, CHAR_LO, CHAR_HI);
        end else begin
            case (state_q)
                ST_PRESENT: begin
                    if (guess_ready) begin
                        count_d = (count_q == 32'hFFFF_FFFF) ? count_q : count_q + 32'd1;
                        state_d = ST_ADVANCE;
                    end
                    if (stop) state_d = ST_IDLE;
                end
                ST_ADVANCE: begin
                    if (stop) begin
                        state_d = ST_IDLE;
                    end else if (carry_top) begin
                        if (len_q < MAX_LEN_W) begin
                            len_d   = len_q + 5'd1;
                            state_d = ST_PRESENT;
                            for (int j = 0; j < MAX_LEN; j++)
                                chars_d[j] = (5'(j) <= len_q) ? CHAR_LO : 8'h00;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end else begin
                        state_d = ST_PRESENT;
                        for (int j = 0; j < MAX_LEN; j++)
                            chars_d[j] = (5'(j) < len_q) ? nxt[j] : 8'h00;
                    end
                end
                ST_DONE: begin
                    if (stop) state_d = ST_IDLE;
                end
                default: ;
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            chars_q <= '0;
            len_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            chars_q <= chars_d;
            len_q   <= len_d;
            count_q <= count_d;
        end
    end

    // Pack characters MSB-first into the 128-bit guess; unused bytes are zero.
    always_comb begin
        guess = '0;
        for (int j = 0; j < MAX_LEN; j++)
            guess[GUESS_W-1-8*j -: 8] = chars_q[j];
    end

    assign guess_valid = (state_q == ST_PRESENT);
    assign busy        = (state_q != ST_IDLE);
    assign exhausted   = (state_q == ST_DONE);
    assign guess_len   = len_q;
    assign count       = count_q;

endmodule

// File: tb/tb_md5_guess_generator.sv
// Bench for md5_guess_generator: numeric odometer model checked every cycle,
// plus literal expectations on the accepted-guess log.
module tb_md5_guess_generator;

    localparam int         ML  = 2;
    localparam logic [7:0] LO  = 8'h61;
    localparam logic [7:0] HI  = 8'h7A;
    localparam int         RNG = 26;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic         stop = 1'b0;
    logic         guess_ready = 1'b0;
    logic [2:0]   increment = 3'd1;
    logic [7:0]   starting_position = 8'h61;
    logic         guess_valid;
    logic [127:0] guess;
    logic [4:0]   guess_len;
    logic         busy;
    logic         exhausted;
    logic [31:0]  count;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    md5_guess_generator #(.MAX_LEN(ML), .CHAR_LO(LO), .CHAR_HI(HI)) dut (
        .clk(clk), .reset(reset), .start(start), .increment(increment),
        .starting_position(starting_position), .stop(stop), .guess_ready(guess_ready),
        .guess_valid(guess_valid), .guess(guess), .guess_len(guess_len),
        .busy(busy), .exhausted(exhausted), .count(count)
    );

    // Model: the guess is a base-26 number of a given length.
    typedef enum int {M_IDLE, M_SHOW, M_GAP, M_END} mph_t;
    mph_t        m_ph;
    int          m_val;
    int          m_len;
    logic [31:0] m_cnt;
    logic [127:0] acc_g[$];
    int           acc_l[$];

    function automatic int pw(input int n);
        int r = 1;
        repeat (n) r = r * RNG;
        return r;
    endfunction

    function automatic logic [127:0] model_guess(input int v, input int l);
        logic [127:0] g = '0;
        for (int i = 0; i < l; i++)
            g[127-8*i -: 8] = 8'(int'(LO) + (v / pw(l - 1 - i)) % RNG);
        return g;
    endfunction

    function automatic logic [127:0] s2g(input string s);
        logic [127:0] g = '0;
        for (int i = 0; i < s.len(); i++) g[127-8*i -: 8] = s[i];
        return g;
    endfunction

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model advanced on each clock from the sampled inputs.
    always @(posedge clk or negedge reset) begin : mdl
        mph_t        ph;
        int          v, l, eff, nv;
        logic [31:0] c;
        logic        load;
        if (!reset) begin
            m_ph <= M_IDLE; m_val <= 0; m_len <= 0; m_cnt <= '0;
        end else begin
            ph = m_ph; v = m_val; l = m_len; c = m_cnt;
            eff = (increment == 3'd0) ? 1 : int'(increment);
            load = start && (m_ph == M_IDLE || (m_ph == M_END && !stop));
            if (load) begin
                ph = M_SHOW; l = 1; c = '0;
                v = (starting_position >= LO && starting_position <= HI) ?
                    int'(starting_position) - int'(LO) : 0;
            end else begin
                case (m_ph)
                    M_SHOW: begin
                        if (guess_ready) begin
                            acc_g.push_back(guess);
                            acc_l.push_back(int'(guess_len));
                            if (c != 32'hFFFF_FFFF) c = c + 32'd1;
                            ph = M_GAP;
                        end
                        if (stop) ph = M_IDLE;
                    end
                    M_GAP: begin
                        if (stop) ph = M_IDLE;
                        else begin
                            nv = v + eff;
                            if (nv >= pw(l)) begin
                                if (l < ML) begin l = l + 1; v = 0; ph = M_SHOW; end
                                else ph = M_END;
                            end else begin
                                v = nv; ph = M_SHOW;
                            end
                        end
                    end
                    M_END: if (stop) ph = M_IDLE;
                    default: ;
                endcase
            end
            m_ph <= ph; m_val <= v; m_len <= l; m_cnt <= c;
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        check("guess_valid", 128'(guess_valid), 128'(m_ph == M_SHOW));
        check("busy",        128'(busy),        128'(m_ph != M_IDLE));
        check("exhausted",   128'(exhausted),   128'(m_ph == M_END));
        check("count",       128'(count),       128'(m_cnt));
        check("guess_len",   128'(guess_len),   128'(m_len));
        check("guess",       guess,             model_guess(m_val, m_len));
    end

    task automatic step_to();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [7:0] sp, input logic [2:0] inc);
        starting_position = sp;
        increment = inc;
        start = 1'b1;
        step_to();
        start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        step_to();
        stop = 1'b0;
        step_to();
    endtask

    task automatic clear_log();
        acc_g.delete();
        acc_l.delete();
    endtask

    task automatic wait_acc(input int n, input int budget);
        int k = 0;
        while (acc_g.size() < n && k < budget) begin step_to(); k++; end
        checks++;
        if (acc_g.size() < n) begin
            failures++;
            $display("FAIL wait_acc accepted=%0d required=%0d", acc_g.size(), n);
        end
    endtask

    initial begin
        int k;
        // Reset state
        step_to(); step_to(); step_to();
        check("rst_valid", 128'(guess_valid), 128'(0));
        check("rst_count", 128'(count), 128'(0));
        check("rst_guess", guess, 128'(0));
        reset = 1'b1;
        step_to();

        // Basic sequence a..z, aa, ab
        clear_log();
        guess_ready = 1'b1;
        pulse_start(8'h61, 3'd1);
        wait_acc(28, 200);
        if (acc_g.size() >= 28) begin
            check("basic_0_a",   acc_g[0],  s2g("a"));
            check("basic_25_z",  acc_g[25], s2g("z"));
            check("basic_26_aa", acc_g[26], s2g("aa"));
            check("basic_26_len", 128'(acc_l[26]), 128'(2));
            check("basic_27_ab", acc_g[27], s2g("ab"));
        end
        do_stop();

        // Stop coinciding with an accept at count=10
        clear_log();
        pulse_start(8'h61, 3'd1);
        k = 0;
        while (!(guess_valid && count == 32'd10) && k < 100) begin step_to(); k++; end
        check("stop_reached", 128'(guess_valid && count == 32'd10), 128'(1));
        stop = 1'b1;
        step_to();
        stop = 1'b0;
        check("stop_count", 128'(count), 128'(11));
        check("stop_busy",  128'(busy), 128'(0));
        check("stop_valid", 128'(guess_valid), 128'(0));
        check("stop_guess", guess, s2g("k"));
        step_to();

        // Step 3 with wrap and length growth
        clear_log();
        pulse_start(8'h78, 3'd3);
        wait_acc(11, 100);
        if (acc_g.size() >= 11) begin
            check("wrap_0_x",   acc_g[0],  s2g("x"));
            check("wrap_1_aa",  acc_g[1],  s2g("aa"));
            check("wrap_2_ad",  acc_g[2],  s2g("ad"));
            check("wrap_9_ay",  acc_g[9],  s2g("ay"));
            check("wrap_10_bb", acc_g[10], s2g("bb"));
        end
        do_stop();

        // Zero increment and out-of-range starting position
        clear_log();
        pulse_start(8'h30, 3'd0);
        wait_acc(3, 20);
        if (acc_g.size() >= 3) begin
            check("inc0_0_a", acc_g[0], s2g("a"));
            check("inc0_1_b", acc_g[1], s2g("b"));
            check("inc0_2_c", acc_g[2], s2g("c"));
        end
        do_stop();

        // Backpressure on "c"
        guess_ready = 1'b0;
        clear_log();
        pulse_start(8'h63, 3'd1);
        repeat (5) begin
            check("bp_valid", 128'(guess_valid), 128'(1));
            check("bp_guess", guess, s2g("c"));
            check("bp_count", 128'(count), 128'(0));
            step_to();
        end
        guess_ready = 1'b1;
        step_to();
        guess_ready = 1'b0;
        check("bp_count1", 128'(count), 128'(1));
        step_to();
        check("bp_next_d", guess, s2g("d"));
        do_stop();

        // Exhaustion at MAX_LEN=2
        clear_log();
        guess_ready = 1'b1;
        pulse_start(8'h61, 3'd1);
        k = 0;
        while (!exhausted && k < 2000) begin step_to(); k++; end
        check("ex_flag",  128'(exhausted), 128'(1));
        check("ex_count", 128'(count), 128'(702));
        check("ex_valid", 128'(guess_valid), 128'(0));
        check("ex_accepts", 128'(acc_g.size()), 128'(702));
        if (acc_g.size() > 0) check("ex_last_zz", acc_g[acc_g.size()-1], s2g("zz"));
        pulse_start(8'h61, 3'd1);
        check("re_valid", 128'(guess_valid), 128'(1));
        check("re_count", 128'(count), 128'(0));
        check("re_guess", guess, s2g("a"));
        repeat (6) step_to();

        // Asynchronous reset while a guess is presented
        k = 0;
        while (!guess_valid && k < 10) begin step_to(); k++; end
        #1;
        reset = 1'b0;
        #1;
        check("arst_valid", 128'(guess_valid), 128'(0));
        check("arst_busy",  128'(busy), 128'(0));
        check("arst_count", 128'(count), 128'(0));
        check("arst_guess", guess, 128'(0));
        check("arst_len",   128'(guess_len), 128'(0));
        step_to(); step_to(); step_to();
        reset = 1'b1;
        step_to(); step_to();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
